// File: rtl/demux_buf.sv
// One-word-per-output demultiplexing buffer: each accepted word is routed by in_sel
// into its own registered slot. Each slot drains independently through a valid/ready handshake.
module demux_buf #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned SEL_WIDTH  = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [SEL_WIDTH-1:0]         in_sel,
    output logic [(2**SEL_WIDTH)-1:0]    out_valid,
    input  logic [(2**SEL_WIDTH)-1:0]    out_ready,
    output logic [DATA_WIDTH-1:0]        out_data [(2**SEL_WIDTH)-1:0],
    output logic [SEL_WIDTH:0]           occupancy
);

    localparam int unsigned N  = 2**SEL_WIDTH;
    localparam int unsigned CW = SEL_WIDTH + 1;

    logic [N-1:0]          r_full;
    logic [DATA_WIDTH-1:0] r_data [N-1:0];
    logic [CW-1:0]         r_occ;

    logic                  w_fire_in;
    logic [N-1:0]          w_load;
    logic [N-1:0]          w_full_nxt;
    logic [CW-1:0]         w_occ_nxt;

    // Target slot can accept when empty or draining this cycle; never depends on in_valid.
    assign in_ready  = ~r_full[in_sel] | out_ready[in_sel];
    assign w_fire_in = in_valid & in_ready;

    // Per-slot load strobes, next full flags and the resulting occupancy.
    always_comb begin
        w_load     = '0;
        w_full_nxt = '0;
        w_occ_nxt  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_load[i]     = w_fire_in && (in_sel == SEL_WIDTH'(i));
            w_full_nxt[i] = w_load[i] | (r_full[i] & ~out_ready[i]);
            w_occ_nxt     = w_occ_nxt + CW'(w_full_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= '0;
            r_occ  <= '0;
        end else begin
            r_full <= w_full_nxt;
            r_occ  <= w_occ_nxt;
        end
    end

    // Data registers only load on an accepted word; drained slots keep stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= in_data;
                end
            end
        end
    end

    assign out_valid = r_full;
    assign out_data  = r_data;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_demux_buf.sv
// Scoreboard bench for demux_buf: per-slot expected-word queues filled by the driver,
// drained and compared by an independent mid-cycle monitor.
module tb_demux_buf;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 2;
    localparam int unsigned N  = 4;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_sel;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;
    logic [DW-1:0] out_data [N-1:0];
    logic [SW:0]   occupancy;

    demux_buf #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words accepted but not yet delivered, per slot.
    logic [DW-1:0] q [N][$];
    logic [N-1:0]  exp_valid    = '0;
    logic          exp_in_ready = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus just after the edge and record what the model expects.
    task automatic drive(input logic v, input logic [SW-1:0] s, input logic [DW-1:0] d,
                         input logic [N-1:0] r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        for (int i = 0; i < N; i++) exp_valid[i] = (q[i].size() != 0);
        exp_in_ready = !exp_valid[s] || r[s];
        if (v && exp_in_ready) q[s].push_back(d);
    endtask

    // Mid-cycle monitor: compares handshake outputs and pops delivered words.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("in_ready", 32'(in_ready), 32'(exp_in_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("occupancy", 32'(occupancy), 32'($countones(out_valid)));
            for (int i = 0; i < N; i++) begin
                if (exp_valid[i] && q[i].size() != 0)
                    chk($sformatf("out_data[%0d]", i), 32'(out_data[i]), 32'(q[i][0]));
                if (out_valid[i] && out_ready[i]) begin
                    if (q[i].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL deliver[%0d]: got word %0h expected none", i, out_data[i]);
                    end else begin
                        void'(q[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic mid_check_idle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_data0", 32'(out_data[0]), 32'h0);
        #11;
        reset_n = 1'b1;

        // Single fill into slot 2.
        drive(1'b1, 2'd2, 8'hA5, 4'b0000);
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        mid_check_idle();
        chk("fill_valid", 32'(out_valid), 32'h4);
        chk("fill_data2", 32'(out_data[2]), 32'hA5);
        chk("fill_occ", 32'(occupancy), 32'h1);

        // Head-of-line block on a full, stalled slot.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd2, 8'h3C, 4'b0000);
            mid_check_idle();
            chk("hol_in_ready", 32'(in_ready), 32'h0);
            chk("hol_data2", 32'(out_data[2]), 32'hA5);
        end

        // Simultaneous drain and refill of slot 2: no bubble.
        drive(1'b1, 2'd2, 8'h3C, 4'b0100);
        mid_check_idle();
        chk("pass_in_ready", 32'(in_ready), 32'h1);
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        mid_check_idle();
        chk("pass_valid2", 32'(out_valid[2]), 32'h1);
        chk("pass_data2", 32'(out_data[2]), 32'h3C);
        chk("pass_occ", 32'(occupancy), 32'h1);

        // Fill every slot, then drain all in one cycle.
        drive(1'b0, 2'd0, 8'h00, 4'b0100);
        for (int k = 0; k < N; k++) drive(1'b1, SW'(k), 8'(8'h10 + k), 4'b0000);
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        mid_check_idle();
        chk("full_valid", 32'(out_valid), 32'hF);
        chk("full_occ", 32'(occupancy), 32'h4);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        mid_check_idle();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_occ", 32'(occupancy), 32'h0);

        // Asynchronous reset mid-cycle with slots 0 and 1 full.
        drive(1'b1, 2'd0, 8'h55, 4'b0000);
        drive(1'b1, 2'd1, 8'h66, 4'b0000);
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_occ", 32'(occupancy), 32'h0);
        chk("arst_data1", 32'(out_data[1]), 32'h0);
        for (int i = 0; i < N; i++) q[i].delete();
        exp_valid    = '0;
        exp_in_ready = 1'b1;
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_in_ready", 32'(in_ready), 32'h1);
        chk("rst_hold_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        #1;
        reset_n = 1'b1;

        // Randomized traffic.
        for (int k = 0; k < 200; k++) begin
            drive(1'($urandom_range(0, 1)), SW'($urandom_range(0, N - 1)),
                  DW'($urandom), N'($urandom));
        end

        // Drain and confirm nothing was lost.
        repeat (3) drive(1'b0, 2'd0, 8'h00, 4'b1111);
        mid_check_idle();
        for (int i = 0; i < N; i++) chk($sformatf("leftover[%0d]", i), 32'(q[i].size()), 32'h0);
        chk("end_occ", 32'(occupancy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_buf.md
DEMUX_BUF -- requirements
Module: demux_buf

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 1, giving the payload width in bits.
REQ-002 The block SHALL have parameter SEL_WIDTH, default 1, giving the select width; the number of outputs is N = 2**SEL_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream offers a word.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-007 The block SHALL have port in_data, input, DATA_WIDTH bits: the offered payload.
REQ-008 The block SHALL have port in_sel, input, SEL_WIDTH bits: the destination output index, sampled with in_data.
REQ-009 The block SHALL have port out_valid, output, N bits: bit i means slot i holds a word.
REQ-010 The block SHALL have port out_ready, input, N bits: bit i means consumer i takes slot i's word this cycle.
REQ-011 The block SHALL have port out_data, output, unpacked array [N-1:0] of DATA_WIDTH bits: the contents of slot i.
REQ-012 The block SHALL have port occupancy, output, SEL_WIDTH+1 bits: the count of set out_valid bits.

Function
REQ-013 The block SHALL hold one registered slot per output: a data register and a full flag driving out_data[i] and out_valid[i].
REQ-014 A transfer in SHALL occur when in_valid and in_ready are both 1 on a rising clk edge.
REQ-015 A transfer out of slot i SHALL occur when out_valid[i] and out_ready[i] are both 1 on a rising clk edge.
REQ-016 in_ready SHALL equal (NOT out_valid[in_sel]) OR out_ready[in_sel], computed combinationally in the current cycle.
REQ-017 in_ready SHALL be independent of in_valid, so that no combinational loop exists through the upstream.
REQ-018 On a transfer in, slot in_sel SHALL load in_data and set its full flag, so out_valid[in_sel] is 1 from the next cycle (latency 1).
REQ-019 On simultaneous transfer out and transfer in on the same slot, the slot SHALL load the new word and stay full, with no bubble.
REQ-020 On a transfer out with no transfer in to that slot, the slot SHALL clear its full flag; out_data holds its stale value and is don't-care.
REQ-021 Slots SHALL operate independently; draining slot i in the same cycle as a transfer into slot j (j != i) SHALL affect neither slot's other behaviour.
REQ-022 When slot in_sel is full and out_ready[in_sel] is 0, in_ready SHALL be 0 and in_data SHALL be ignored, even if other slots are empty (head-of-line blocking).
REQ-023 out_data[i] SHALL remain stable while out_valid[i] is 1 and out_ready[i] is 0.
REQ-024 occupancy SHALL be registered and updated each cycle by +1 (fill only), -k (k drains only), or unchanged (fill plus drain on the same slot), saturating only at N (all slots full).
REQ-025 in_valid with in_ready 0 SHALL change no state.

Reset
REQ-026 While reset_n is 0, all full flags SHALL be 0, occupancy SHALL be 0, and out_data SHALL be 0, asynchronously and regardless of clk.
REQ-027 Reset asserted mid-transfer SHALL discard all held words, with no partial transfer recorded.
REQ-028 After reset_n deasserts, the first transfer SHALL occur no earlier than the first rising clk edge with reset_n at 1.
REQ-029 While reset_n is 0, in_ready SHALL read 1, but no transfer SHALL be captured.

Verification (DATA_WIDTH=8, SEL_WIDTH=2)
REQ-030 Scenario: reset_n=0 then 1, in_valid=1, in_data=8'hA5, in_sel=2, out_ready=0 -> next cycle out_valid=4'b0100, out_data[2]=8'hA5, occupancy=1.
REQ-031 Scenario: slot 2 full, out_ready=0, in_sel=2, in_data=8'h3C -> in_ready=0; out_data[2] stays 8'hA5 for 5 cycles.
REQ-032 Scenario: slot 2 full, out_ready[2]=1, in_sel=2, in_data=8'h3C -> in_ready=1; next cycle out_valid[2]=1, out_data[2]=8'h3C, occupancy unchanged.
REQ-033 Scenario: fill slots 0..3 with 8'h10..8'h13 over 4 cycles, out_ready=0 -> out_valid=4'b1111, occupancy=4; then out_ready=4'b1111 for 1 cycle -> out_valid=0, occupancy=0.
REQ-034 Scenario: slots 0 and 1 full, assert reset_n=0 mid-cycle -> out_valid=0 and occupancy=0 immediately, before the next clk edge.
REQ-035 Scenario: 200 cycles of random in_valid/in_sel/in_data/out_ready -> a scoreboard confirms per-slot in-order delivery with no loss or duplication, and occupancy always equals popcount(out_valid).
